me_stage: RTL and testbench

- Memory-access stage of the 5-stage LoongArch pipeline. Sits between the execute stage (EX_to_ME_Bus, 76 bits) and write-back.
- Latches the EX payload under a valid/allow-in handshake and waits for the load data response.
- Aligns, masks and sign-extends sub-word load data, then forwards the final result to ID and WB.

---
 rtl/me_stage_pkg.sv | 30 +++
 rtl/me_stage_load_align.sv | 37 +++
 rtl/me_stage.sv | 124 ++++++++++++
 tb/tb_me_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_stage_pkg.sv
// Shared definitions for the memory-access stage: bus sizes, EX->ME bus field
// positions, load-flag bit positions and load FSM state encoding.
package me_stage_pkg;

    localparam int EX_to_ME_Bus_Size = 76;
    localparam int ME_to_WB_Bus_Size = 70;

    // EX->ME bus layout: {dest_flag, pc, alu_result, res_from_mem, gr_we, dest}
    localparam int FLAG_HI  = 75;
    localparam int FLAG_LO  = 71;
    localparam int PC_HI    = 70;
    localparam int PC_LO    = 39;
    localparam int ALU_HI   = 38;
    localparam int ALU_LO   = 7;
    localparam int RES_MEM  = 6;
    localparam int GR_WE    = 5;
    localparam int DEST_HI  = 4;

    // dest_flag = {signed, byte, half, offset[1:0]}
    localparam int FLAG_SIGNED = 4;
    localparam int FLAG_BYTE   = 3;
    localparam int FLAG_HALF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } me_state_e;

endpackage

// File: rtl/me_stage_load_align.sv
// Combinational load alignment: selects the addressed byte/half/word from the
// response word and zero- or sign-extends it to 32 bits.
module me_stage_load_align
    import me_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [4:0]  i_flag,
    output logic [31:0] o_value
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_signed = i_flag[FLAG_SIGNED];
    assign w_byte   = w_lane[i_flag[1:0]];
    // Halfword select only looks at offset[1]; offset[0] is ignored.
    assign w_half   = i_flag[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_value = i_rdata;
        if (i_flag[FLAG_BYTE]) begin
            o_value = {{24{w_signed & w_byte[7]}}, w_byte};
        end else if (i_flag[FLAG_HALF]) begin
            o_value = {{16{w_signed & w_half[15]}}, w_half};
        end
    end

endmodule

// File: rtl/me_stage.sv
// LoongArch memory-access stage: latches the EX payload, waits for the load
// response (buffering it under WB backpressure) and forwards the aligned result.
// Optional macro ME_LOAD_FWD_EN: release the ID load stall once data is available.
module me_stage
    import me_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         EX_to_ME_Valid,
    input  logic [EX_to_ME_Bus_Size-1:0] EX_to_ME_Bus,
    output logic                         ME_Allow_in,
    input  logic [31:0]                  data_sram_rdata,
    input  logic                         data_sram_data_ok,
    input  logic                         WB_Allow_in,
    output logic                         ME_to_WB_Valid,
    output logic [ME_to_WB_Bus_Size-1:0] ME_to_WB_Bus,
    output logic [4:0]                   ME_dest,
    output logic [31:0]                  ME_Forward_Res,
    output logic                         ME_to_ID_Ld_stall
);

    me_state_e                    r_state;
    me_state_e                    w_state_next;
    logic                         r_me_valid;
    logic [EX_to_ME_Bus_Size-1:0] r_payload;
    logic [31:0]                  r_data_buf;
    logic                         r_data_buf_valid;

    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_pc;
    logic [31:0] w_alu_result;
    logic [4:0]  w_flag;
    logic        w_data_ok_eff;
    logic [31:0] w_rdata_eff;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_accept_load;
    logic        w_buf_capture;
    logic [31:0] w_load_value;
    logic [31:0] w_final_result;

    assign w_flag         = r_payload[FLAG_HI:FLAG_LO];
    assign w_pc           = r_payload[PC_HI:PC_LO];
    assign w_alu_result   = r_payload[ALU_HI:ALU_LO];
    assign w_res_from_mem = r_payload[RES_MEM];
    assign w_gr_we        = r_payload[GR_WE];
    assign w_dest         = r_payload[DEST_HI:0];

    // A response only counts while waiting; stale data_ok elsewhere is dropped.
    assign w_data_ok_eff  = ((r_state == ST_WAIT) && data_sram_data_ok) || r_data_buf_valid;
    assign w_rdata_eff    = r_data_buf_valid ? r_data_buf : data_sram_rdata;

    assign w_ready_go     = !w_res_from_mem || w_data_ok_eff;
    assign ME_Allow_in    = !r_me_valid || (w_ready_go && WB_Allow_in);
    assign ME_to_WB_Valid = r_me_valid && w_ready_go;
    assign w_accept       = ME_Allow_in && EX_to_ME_Valid;
    assign w_accept_load  = w_accept && EX_to_ME_Bus[RES_MEM];

    me_stage_load_align u_load_align (
        .i_rdata (w_rdata_eff),
        .i_flag  (w_flag),
        .o_value (w_load_value)
    );

    assign w_final_result = w_res_from_mem ? w_load_value : w_alu_result;
    assign ME_Forward_Res = w_final_result;
    assign ME_to_WB_Bus   = {w_pc, w_final_result, w_gr_we, w_dest};
    assign ME_dest        = (r_me_valid && w_gr_we) ? w_dest : 5'd0;

`ifdef ME_LOAD_FWD_EN
    assign ME_to_ID_Ld_stall = r_me_valid && w_res_from_mem && !w_data_ok_eff;
`else
    assign ME_to_ID_Ld_stall = r_me_valid && w_res_from_mem;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_buf_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_load) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    if (WB_Allow_in) begin
                        w_state_next = w_accept_load ? ST_WAIT : ST_IDLE;
                    end else begin
                        w_state_next  = ST_HOLD;
                        w_buf_capture = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (WB_Allow_in) w_state_next = w_accept_load ? ST_WAIT : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_me_valid       <= 1'b0;
            r_data_buf_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (ME_Allow_in) r_me_valid <= EX_to_ME_Valid;
            if (w_buf_capture) begin
                r_data_buf_valid <= 1'b1;
            end else if (r_data_buf_valid && WB_Allow_in) begin
                r_data_buf_valid <= 1'b0;
            end
        end
    end

    // Datapath registers need no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_accept) r_payload <= EX_to_ME_Bus;
        if (w_buf_capture) r_data_buf <= data_sram_rdata;
    end

endmodule

// File: tb/tb_me_stage.sv
// Self-checking bench for me_stage: directed scenarios plus a randomized run
// against a transaction-level reference model of the stage.
module tb_me_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [75:0] ex_bus;
    logic        allow_in;
    logic [31:0] rdata;
    logic        data_ok;
    logic        wb_allow;
    logic        wb_valid;
    logic [69:0] wb_bus;
    logic [4:0]  me_dest;
    logic [31:0] fwd_res;
    logic        ld_stall;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ME_LOAD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    me_stage dut (
        .clk               (clk),
        .reset             (reset),
        .EX_to_ME_Valid    (ex_valid),
        .EX_to_ME_Bus      (ex_bus),
        .ME_Allow_in       (allow_in),
        .data_sram_rdata   (rdata),
        .data_sram_data_ok (data_ok),
        .WB_Allow_in       (wb_allow),
        .ME_to_WB_Valid    (wb_valid),
        .ME_to_WB_Bus      (wb_bus),
        .ME_dest           (me_dest),
        .ME_Forward_Res    (fwd_res),
        .ME_to_ID_Ld_stall (ld_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [75:0] make_bus(input logic [4:0] f, input logic [31:0] pc,
                                             input logic [31:0] alu, input logic rfm,
                                             input logic we, input logic [4:0] d);
        return {f, pc, alu, rfm, we, d};
    endfunction

    // Reference extraction with shifts and masks on the whole word.
    function automatic logic [31:0] ref_load(input logic [4:0] f, input logic [31:0] w);
        logic [31:0] v;
        if (f[3]) begin
            v = (w >> (int'(f[1:0]) * 8)) & 32'h0000_00FF;
            if (f[4] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (f[2]) begin
            v = (w >> (f[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (f[4] && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        ex_valid = 1'b1;
        ex_bus   = make_bus(5'b0, 32'h1C00_0000, 32'h0, 1'b1, 1'b1, 5'd7);
        data_ok  = 1'b1;
        rdata    = 32'h0;
        wb_allow = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
        n_cmp++; if (me_dest !== 5'd0) begin n_bad++; $display("FAIL reset_me_dest got=%0d want=0", me_dest); end
        n_cmp++; if (ld_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", ld_stall); end
        n_cmp++; if (allow_in !== 1'b1) begin n_bad++; $display("FAIL reset_allow_in got=%b want=1", allow_in); end
        ex_valid = 1'b0;
        data_ok  = 1'b0;
        reset    = 1'b0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_non_load();
        @(negedge clk);
        ex_valid = 1'b1;
        ex_bus   = make_bus(5'b0, 32'h1C00_0010, 32'h1234_5678, 1'b0, 1'b1, 5'd5);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL nonload_valid got=%b want=1", wb_valid); end
        n_cmp++; if (wb_bus !== {32'h1C00_0010, 32'h1234_5678, 1'b1, 5'd5}) begin n_bad++; $display("FAIL nonload_bus got=%h want=%h", wb_bus, {32'h1C00_0010, 32'h1234_5678, 1'b1, 5'd5}); end
        n_cmp++; if (me_dest !== 5'd5) begin n_bad++; $display("FAIL nonload_dest got=%0d want=5", me_dest); end
        n_cmp++; if (ld_stall !== 1'b0) begin n_bad++; $display("FAIL nonload_stall got=%b want=0", ld_stall); end
        $display("non_load: result=%h dest=%0d", wb_bus[37:6], me_dest);
        @(posedge clk);
    endtask

    task automatic test_load_ext();
        logic [4:0]  flags [4] = '{5'b11011, 5'b01011, 5'b10110, 5'b00000};
        logic [31:0] words [4] = '{32'h80AA_BBCC, 32'h80AA_BBCC, 32'h8001_0000, 32'h8001_0000};
        logic [31:0] wants [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h8001_0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex_valid = 1'b1;
            ex_bus   = make_bus(flags[i], 32'h1C00_0100 + 32'(i * 4), 32'h0000_1003, 1'b1, 1'b1, 5'd9);
            @(posedge clk);
            @(negedge clk);
            ex_valid = 1'b0;
            data_ok  = 1'b1;
            rdata    = words[i];
            #1;
            n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL load_ext%0d_valid got=%b want=1", i, wb_valid); end
            n_cmp++; if (wb_bus[37:6] !== wants[i]) begin n_bad++; $display("FAIL load_ext%0d_result got=%h want=%h", i, wb_bus[37:6], wants[i]); end
            n_cmp++; if (fwd_res !== wants[i]) begin n_bad++; $display("FAIL load_ext%0d_fwd got=%h want=%h", i, fwd_res, wants[i]); end
            n_cmp++; if (ld_stall !== !FWD) begin n_bad++; $display("FAIL load_ext%0d_stall got=%b want=%b", i, ld_stall, !FWD); end
            $display("load_ext %0d: flag=%b rdata=%h result=%h", i, flags[i], words[i], wb_bus[37:6]);
            @(posedge clk);
            @(negedge clk);
            data_ok = 1'b0;
        end
    endtask

    task automatic test_delayed_data_ok();
        logic [31:0] word;
        word = $urandom;
        @(negedge clk);
        ex_valid = 1'b1;
        ex_bus   = make_bus(5'b0, 32'h1C00_0200, 32'h0, 1'b1, 1'b1, 5'd3);
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            data_ok  = 1'b0;
            #1;
            n_cmp++; if (allow_in !== 1'b0) begin n_bad++; $display("FAIL delay%0d_allow got=%b want=0", c, allow_in); end
            n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL delay%0d_valid got=%b want=0", c, wb_valid); end
            n_cmp++; if (ld_stall !== 1'b1) begin n_bad++; $display("FAIL delay%0d_stall got=%b want=1", c, ld_stall); end
            @(posedge clk);
        end
        @(negedge clk);
        data_ok = 1'b1;
        rdata   = word;
        #1;
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL delay_done_valid got=%b want=1", wb_valid); end
        n_cmp++; if (allow_in !== 1'b1) begin n_bad++; $display("FAIL delay_done_allow got=%b want=1", allow_in); end
        n_cmp++; if (wb_bus[37:6] !== word) begin n_bad++; $display("FAIL delay_done_result got=%h want=%h", wb_bus[37:6], word); end
        n_cmp++; if (ld_stall !== !FWD) begin n_bad++; $display("FAIL delay_done_stall got=%b want=%b", ld_stall, !FWD); end
        $display("delayed_data_ok: result=%h after 3 wait cycles", wb_bus[37:6]);
        @(posedge clk);
        @(negedge clk);
        data_ok = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        ex_valid = 1'b1;
        ex_bus   = make_bus(5'b0, 32'h1C00_0300, 32'h0, 1'b1, 1'b1, 5'd4);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        data_ok  = 1'b1;
        rdata    = 32'hDEAD_BEEF;
        wb_allow = 1'b0;
        #1;
        n_cmp++; if (allow_in !== 1'b0) begin n_bad++; $display("FAIL bp_arrive_allow got=%b want=0", allow_in); end
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            data_ok  = (c == 1);
            rdata    = $urandom;
            wb_allow = (c == 2);
            #1;
            n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold%0d_valid got=%b want=1", c, wb_valid); end
            n_cmp++; if (wb_bus[37:6] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bp_hold%0d_result got=%h want=deadbeef", c, wb_bus[37:6]); end
            n_cmp++; if (allow_in !== (c == 2)) begin n_bad++; $display("FAIL bp_hold%0d_allow got=%b want=%b", c, allow_in, c == 2); end
            @(posedge clk);
        end
        @(negedge clk);
        data_ok = 1'b0;
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL bp_after_valid got=%b want=0", wb_valid); end
        $display("backpressure: held result delivered to WB");
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        ex_valid = 1'b1;
        ex_bus   = make_bus(5'b0, 32'h1C00_0400, 32'h0, 1'b1, 1'b1, 5'd6);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h5555_AAAA;
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rstwait_valid got=%b want=0", wb_valid); end
        n_cmp++; if (allow_in !== 1'b1) begin n_bad++; $display("FAIL rstwait_allow got=%b want=1", allow_in); end
        // Accept a non-load with the stale data_ok still asserted; it must pass straight through.
        ex_valid = 1'b1;
        ex_bus   = make_bus(5'b0, 32'h1C00_0404, 32'hCAFE_0001, 1'b0, 1'b1, 5'd8);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL rstwait_next_valid got=%b want=1", wb_valid); end
        n_cmp++; if (wb_bus[37:6] !== 32'hCAFE_0001) begin n_bad++; $display("FAIL rstwait_next_result got=%h want=cafe0001", wb_bus[37:6]); end
        @(posedge clk);
        @(negedge clk);
        data_ok = 1'b0;
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rstwait_idle_valid got=%b want=0", wb_valid); end
        $display("reset_mid_wait: load dropped, stage idle");
    endtask

    task automatic test_random();
        logic        m_valid = 1'b0, m_load = 1'b0, m_got = 1'b0, m_we = 1'b0;
        int          m_cnt = 0;
        logic [31:0] m_word = '0, m_pc = '0, m_alu = '0;
        logic [4:0]  m_flag = '0, m_dest = '0;
        logic [4:0]  n_flag, n_dest;
        logic [31:0] n_pc, n_alu, e_res;
        logic        n_rfm, n_we, waiting, ready, e_allow, e_wbv, e_stall;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            waiting = m_valid && m_load && !m_got;
            if (waiting) begin
                data_ok = (m_cnt == 0);
                rdata   = data_ok ? m_word : $urandom;
            end else begin
                data_ok = ($urandom_range(3) == 0);
                rdata   = $urandom;
            end
            wb_allow = ($urandom_range(3) != 0);
            n_flag   = 5'($urandom);
            n_pc     = $urandom;
            n_alu    = $urandom;
            n_rfm    = 1'($urandom);
            n_we     = 1'($urandom);
            n_dest   = 5'($urandom);
            ex_valid = 1'($urandom);
            ex_bus   = make_bus(n_flag, n_pc, n_alu, n_rfm, n_we, n_dest);
            #1;
            ready   = !m_load || m_got || (waiting && data_ok);
            e_allow = !m_valid || (ready && wb_allow);
            e_wbv   = m_valid && ready;
            e_stall = m_valid && m_load && !(FWD && ready);
            e_res   = m_load ? ref_load(m_flag, m_word) : m_alu;
            n_cmp++; if (allow_in !== e_allow) begin n_bad++; $display("FAIL rand%0d_allow got=%b want=%b", cyc, allow_in, e_allow); end
            n_cmp++; if (wb_valid !== e_wbv) begin n_bad++; $display("FAIL rand%0d_valid got=%b want=%b", cyc, wb_valid, e_wbv); end
            n_cmp++; if (ld_stall !== e_stall) begin n_bad++; $display("FAIL rand%0d_stall got=%b want=%b", cyc, ld_stall, e_stall); end
            n_cmp++; if (me_dest !== ((m_valid && m_we) ? m_dest : 5'd0)) begin n_bad++; $display("FAIL rand%0d_dest got=%0d want=%0d", cyc, me_dest, (m_valid && m_we) ? m_dest : 5'd0); end
            if (e_wbv) begin
                n_cmp++; if (wb_bus !== {m_pc, e_res, m_we, m_dest}) begin n_bad++; $display("FAIL rand%0d_bus got=%h want=%h", cyc, wb_bus, {m_pc, e_res, m_we, m_dest}); end
                n_cmp++; if (fwd_res !== e_res) begin n_bad++; $display("FAIL rand%0d_fwd got=%h want=%h", cyc, fwd_res, e_res); end
                if (wb_allow) $display("rand retire cyc=%0d pc=%h load=%b result=%h", cyc, m_pc, m_load, e_res);
            end
            @(posedge clk);
            if (waiting && data_ok) m_got = 1'b1;
            else if (waiting && m_cnt > 0) m_cnt--;
            if (e_allow) begin
                if (ex_valid) begin
                    m_load = n_rfm;  m_flag = n_flag; m_pc = n_pc; m_alu = n_alu;
                    m_we   = n_we;   m_dest = n_dest; m_got = 1'b0;
                    m_cnt  = $urandom_range(3);
                    m_word = $urandom;
                end
                m_valid = ex_valid;
            end
        end
        @(negedge clk);
        ex_valid = 1'b0;
        data_ok  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_non_load();
        test_load_ext();
        test_delayed_data_ok();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
